// File: rtl/blink_monitor_pkg.sv
// blink_monitor_pkg
//   Constants shared by the blink monitor and the blink generators that
//   drive it:
//   - bm_state_t  : monitor state encoding (IDLE / MEASURE / STALLED).
//   - BM_DEF_*    : default counter width, stall timeout, synchronizer depth
//                   and edge counter width. Keeping these in one place lets a
//                   generator and the monitor watching it agree on
//                   WIDTH/TIMEOUT.
package blink_monitor_pkg;

  typedef enum logic [1:0] {
    BM_IDLE    = 2'd0,
    BM_MEASURE = 2'd1,
    BM_STALLED = 2'd2
  } bm_state_t;

  localparam int BM_DEF_WIDTH       = 32;
  localparam int BM_DEF_TIMEOUT     = 2**25;
  localparam int BM_DEF_SYNC_STAGES = 2;
  localparam int BM_DEF_EDGE_WIDTH  = 16;

endpackage

// File: rtl/blink_monitor_edge_sync.sv
// edge_sync
//   Brings an asynchronous level into the clk domain and flags its rising
//   edges. Reusable wherever a tile needs to watch another tile's toggle line.
//
//   Parameters
//     SYNC_STAGES : synchronizer depth. Must be at least 2.
//
//   Ports
//     clk     in   system clock
//     nrst    in   asynchronous active-low reset
//     d_async in   asynchronous input level
//     q_sync  out  synchronized level (last synchronizer flop)
//     rise    out  q_sync is 1 and was 0 on the previous cycle
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  // Synchronizer chain and edge-detect history.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];

  // Both operands are flop outputs, so rise is stable for the whole cycle.
  assign rise = q_sync & ~s_prev;

endmodule

// File: rtl/blink_monitor.sv
// blink_monitor
//   Measures an asynchronous square wave: period and high time in clock
//   cycles, a count of rising edges, and a flag for an input that has stopped
//   toggling. All outputs are registered.
//
//   Parameters
//     WIDTH       : width of period / high_time and the internal counters
//     SYNC_STAGES : synchronizer depth on blink_in (>= 2)
//     TIMEOUT     : cycles without a rising edge before stalled sets
//                   (must be below 2**WIDTH - 1)
//     EDGE_WIDTH  : width of edge_count
//
//   Ports
//     clk          in   system clock
//     nrst         in   asynchronous active-low reset
//     enable       in   measurement enable
//     blink_in     in   asynchronous input under measurement
//     period       out  cycles between the last two rising edges
//     high_time    out  high cycles within that period
//     period_valid out  one-cycle pulse when period/high_time update
//     stalled      out  no rising edge for TIMEOUT cycles
//     edge_count   out  rising edges seen while enabled (wraps)
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int WIDTH       = BM_DEF_WIDTH,
  parameter int SYNC_STAGES = BM_DEF_SYNC_STAGES,
  parameter int TIMEOUT     = BM_DEF_TIMEOUT,
  parameter int EDGE_WIDTH  = BM_DEF_EDGE_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic                  blink_in,
  output logic [WIDTH-1:0]      period,
  output logic [WIDTH-1:0]      high_time,
  output logic                  period_valid,
  output logic                  stalled,
  output logic [EDGE_WIDTH-1:0] edge_count
);

  localparam logic [WIDTH-1:0]      CNT_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EDGE_WIDTH-1:0] EDGE_ONE    = {{(EDGE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      TIMEOUT_CNT = WIDTH'(TIMEOUT);

  // Add 0 or 1, holding at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] a,
                                               input logic             inc);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {{WIDTH{1'b0}}, inc};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction

  bm_state_t             state, state_nxt;
  logic [WIDTH-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]      hcnt, hcnt_nxt;
  logic [WIDTH-1:0]      period_nxt, high_nxt;
  logic                  pv_nxt, stalled_nxt;
  logic [EDGE_WIDTH-1:0] edge_nxt;
  logic                  s, rise;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .nrst    (nrst),
    .d_async (blink_in),
    .q_sync  (s),
    .rise    (rise)
  );

  // Next-state and next-value logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hcnt_nxt    = hcnt;
    period_nxt  = period;
    high_nxt    = high_time;
    pv_nxt      = 1'b0;
    stalled_nxt = stalled;
    edge_nxt    = edge_count;

    if (!enable) begin
      // Disabled: drop back to IDLE, forget the partial interval, keep the
      // last reported results and the edge count.
      state_nxt   = BM_IDLE;
      cnt_nxt     = '0;
      hcnt_nxt    = '0;
      stalled_nxt = 1'b0;
    end else begin
      unique case (state)
        BM_IDLE: begin
          cnt_nxt  = '0;
          hcnt_nxt = '0;
          // The first edge only starts the interval; there is nothing to
          // report until a second edge closes it.
          if (rise) begin
            state_nxt = BM_MEASURE;
            cnt_nxt   = CNT_ONE;
            hcnt_nxt  = CNT_ONE;
            edge_nxt  = edge_count + EDGE_ONE;
          end
        end

        BM_MEASURE: begin
          // A rise takes priority over the timeout check so an edge landing
          // exactly on TIMEOUT still produces a report.
          if (rise) begin
            period_nxt = cnt;
            high_nxt   = hcnt;
            pv_nxt     = 1'b1;
            cnt_nxt    = CNT_ONE;
            hcnt_nxt   = CNT_ONE;
            edge_nxt   = edge_count + EDGE_ONE;
          end else begin
            cnt_nxt  = sat_inc(cnt, 1'b1);
            hcnt_nxt = sat_inc(hcnt, s);
            if (cnt == TIMEOUT_CNT) begin
              state_nxt   = BM_STALLED;
              stalled_nxt = 1'b1;
            end
          end
        end

        BM_STALLED: begin
          // The interval that ends here spans the stall and is not reported;
          // the edge re-arms measurement like the first edge from IDLE.
          if (rise) begin
            state_nxt   = BM_MEASURE;
            stalled_nxt = 1'b0;
            cnt_nxt     = CNT_ONE;
            hcnt_nxt    = CNT_ONE;
            edge_nxt    = edge_count + EDGE_ONE;
          end else begin
            cnt_nxt  = sat_inc(cnt, 1'b1);
            hcnt_nxt = sat_inc(hcnt, s);
          end
        end

        default: begin
          state_nxt   = BM_IDLE;
          cnt_nxt     = '0;
          hcnt_nxt    = '0;
          stalled_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= BM_IDLE;
      cnt          <= '0;
      hcnt         <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      edge_count   <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hcnt         <= hcnt_nxt;
      period       <= period_nxt;
      high_time    <= high_nxt;
      period_valid <= pv_nxt;
      stalled      <= stalled_nxt;
      edge_count   <= edge_nxt;
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
module tb_blink_monitor;

  localparam int WIDTH      = 8;
  localparam int SYNC       = 2;
  localparam int TIMEOUT    = 100;
  localparam int EDGE_WIDTH = 4;
  localparam int CMAX       = (1 << WIDTH) - 1;
  localparam int EMOD       = 1 << EDGE_WIDTH;

  logic                  clk = 1'b0;
  logic                  clk_run = 1'b0;
  logic                  nrst = 1'b1;
  logic                  enable = 1'b0;
  logic                  blink_in = 1'b0;
  logic [WIDTH-1:0]      period;
  logic [WIDTH-1:0]      high_time;
  logic                  period_valid;
  logic                  stalled;
  logic [EDGE_WIDTH-1:0] edge_count;

  int checks = 0;
  int failures = 0;
  int vcount = 0;

  blink_monitor #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TIMEOUT),
    .EDGE_WIDTH (EDGE_WIDTH)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .enable      (enable),
    .blink_in    (blink_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .stalled     (stalled),
    .edge_count  (edge_count)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the input is a list of per-edge samples; the
  // synchronized level at edge j is the sample taken SYNC edges earlier.
  // A report is the distance between two rising edges and the number of
  // high synchronized samples in between.
  int m;
  bit hist[$];
  int mode;  // 0: not armed, 1: measuring, 2: stalled
  int last;
  int e_period, e_high, e_valid, e_stalled, e_edges;

  function automatic bit s_at(input int j);
    if (j - SYNC < 0) return 1'b0;
    return hist[j - SYNC];
  endfunction

  task automatic model_reset();
    m = 0; hist.delete(); mode = 0; last = 0;
    e_period = 0; e_high = 0; e_valid = 0; e_stalled = 0; e_edges = 0;
  endtask

  task automatic model_step();
    bit r;
    int per, hi;
    r = s_at(m) && !s_at(m - 1);
    e_valid = 0;
    if (!enable) begin
      mode = 0;
      e_stalled = 0;
    end else if (mode == 0) begin
      if (r) begin
        mode = 1; last = m; e_edges = (e_edges + 1) % EMOD;
      end
    end else if (r) begin
      if (mode == 1) begin
        per = m - last;
        hi = 0;
        for (int j = last; j < m; j++) hi += s_at(j);
        e_period = (per > CMAX) ? CMAX : per;
        e_high   = (hi > CMAX) ? CMAX : hi;
        e_valid  = 1;
      end
      mode = 1; e_stalled = 0; last = m; e_edges = (e_edges + 1) % EMOD;
    end else if (mode == 1 && (m - last) == TIMEOUT) begin
      mode = 2; e_stalled = 1;
    end
    hist.push_back(blink_in);
    m++;
  endtask

  // Compare process: step the model on every active edge, check 1 time unit later.
  always begin
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      model_reset();
    end else begin
      model_step();
      #1;
      chk("period", int'(period), e_period);
      chk("high_time", int'(high_time), e_high);
      chk("period_valid", int'(period_valid), e_valid);
      chk("stalled", int'(stalled), e_stalled);
      chk("edge_count", int'(edge_count), e_edges);
      if (period_valid === 1'b1) vcount++;
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      blink_in = v;
    end
  endtask

  task automatic wave(input int p, input int h, input int n);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high"}, int'(high_time), 0);
    chk({tag, "_valid"}, int'(period_valid), 0);
    chk({tag, "_stalled"}, int'(stalled), 0);
    chk({tag, "_edges"}, int'(edge_count), 0);
  endtask

  int vc, ec, pc;

  initial begin
    // Reset with no clock running and a toggling input.
    #1 nrst = 1'b0;
    repeat (4) begin
      #2 blink_in = ~blink_in;
    end
    #1;
    chk_zero("rst_noclk");
    blink_in = 1'b0;
    enable = 1'b1;
    #2 nrst = 1'b1;
    #2 clk_run = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_edges", int'(edge_count), 0);
    chk("idle_period", int'(period), 0);

    // Square wave 8 cycles, 4 high.
    wave(8, 4, 1);
    chk("sq_first_edges", int'(edge_count), 1);
    chk("sq_first_novalid", vcount, 0);
    wave(8, 4, 5);
    chk("sq_period", int'(period), 8);
    chk("sq_high", int'(high_time), 4);
    chk("sq_valids", vcount, 5);
    chk("sq_edges", int'(edge_count), 6);

    // 25% duty at period 20, then switch to period 6.
    wave(20, 5, 3);
    chk("d25_period", int'(period), 20);
    chk("d25_high", int'(high_time), 5);
    wave(6, 3, 4);
    chk("p6_period", int'(period), 6);
    chk("p6_high", int'(high_time), 3);

    // Stall after a rise, then resume.
    vc = vcount;
    drive(1'b1, 3);
    drive(1'b0, 150);
    chk("stall_flag", int'(stalled), 1);
    chk("stall_period_held", int'(period), 6);
    chk("stall_valids", vcount, vc + 1);
    vc = vcount;
    wave(6, 3, 3);
    chk("resume_stalled", int'(stalled), 0);
    chk("resume_period", int'(period), 6);
    chk("resume_valids", vcount, vc + 2);

    // Rise landing exactly on the timeout count.
    drive(1'b1, 50);
    drive(1'b0, 50);
    drive(1'b1, 3);
    drive(1'b0, 3);
    chk("tmo_rise_period", int'(period), 100);
    chk("tmo_rise_high", int'(high_time), 50);
    chk("tmo_rise_stalled", int'(stalled), 0);

    // One-cycle pulses.
    wave(2, 1, 5);
    chk("pulse_period", int'(period), 2);
    chk("pulse_high", int'(high_time), 1);

    // Enable dropped mid-period.
    drive(1'b1, 4);
    drive(1'b0, 2);
    enable = 1'b0;
    ec = edge_count;
    vc = vcount;
    pc = period;
    drive(1'b0, 2);
    wave(8, 4, 3);
    chk("dis_edges", int'(edge_count), ec);
    chk("dis_valids", vcount, vc);
    chk("dis_period", int'(period), pc);
    enable = 1'b1;
    wave(8, 4, 3);
    chk("reen_valids", vcount, vc + 2);
    chk("reen_period", int'(period), 8);
    chk("reen_edges", int'(edge_count), (ec + 3) % EMOD);

    // Asynchronous reset between clock edges.
    wave(8, 4, 2);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    nrst = 1'b1;
    vc = vcount;
    wave(8, 4, 3);
    chk("post_rst_valids", vcount, vc + 2);
    chk("post_rst_edges", int'(edge_count), 3);
    chk("post_rst_period", int'(period), 8);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
